// File: rtl/muldiv_ctrl_pkg.sv
// Shared constants for the EX-stage multiply/divide sequencer.
// Op encodings, FSM state encodings and the HI/LO bus width.
package muldiv_ctrl_pkg;

    localparam logic [1:0] MULDIV_MULT  = 2'b00;
    localparam logic [1:0] MULDIV_MULTU = 2'b01;
    localparam logic [1:0] MULDIV_DIV   = 2'b10;
    localparam logic [1:0] MULDIV_DIVU  = 2'b11;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_MUL      = 3'd1;
    localparam logic [2:0] S_DIV_ZERO = 3'd2;
    localparam logic [2:0] S_DIV_ON   = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    localparam int HILO_W = 64;

endpackage

// File: rtl/muldiv_ctrl_if.sv
// EX-side request/result bundle for muldiv_ctrl.
// master = EX pipeline stage, slave = the sequencer.
interface muldiv_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              flush;
    logic              op_valid;
    logic [1:0]        op;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic              accept;
    logic              stallreq;
    logic              result_valid;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              busy;

    modport master (
        output flush, op_valid, op, src1, src2, accept,
        input  stallreq, result_valid, hi, lo, busy
    );

    modport slave (
        input  flush, op_valid, op, src1, src2, accept,
        output stallreq, result_valid, hi, lo, busy
    );
endinterface

// File: rtl/muldiv_ctrl_div_core.sv
// One restoring shift-subtract divide step on unsigned magnitudes.
// Dividend bits are shifted out of the quotient register MSB-first.
module div_core #(
    parameter int DATA_W = 32
)(
    input  logic [DATA_W-1:0] i_rem,
    input  logic [DATA_W-1:0] i_quo,
    input  logic [DATA_W-1:0] i_dvs,
    output logic [DATA_W-1:0] o_rem,
    output logic [DATA_W-1:0] o_quo
);
    logic [DATA_W:0] w_shift;
    logic [DATA_W:0] w_diff;

    assign w_shift = {i_rem, i_quo[DATA_W-1]};
    assign w_diff  = w_shift - {1'b0, i_dvs};

    // A set MSB on the difference means the trial subtract borrowed.
    always_comb begin
        if (w_diff[DATA_W]) begin
            o_rem = w_shift[DATA_W-1:0];
            o_quo = {i_quo[DATA_W-2:0], 1'b0};
        end else begin
            o_rem = w_diff[DATA_W-1:0];
            o_quo = {i_quo[DATA_W-2:0], 1'b1};
        end
    end
endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer producing {hi,lo} for EX.
// Optional: MULDIV_DIV_EARLY_EXIT_EN short-circuits divides with |src1| < |src2|.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
)(
    input logic          clk,
    input logic          resetn,
    muldiv_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    logic [2:0]          r_state;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic                r_signed;
    logic                r_early;
    logic [DATA_W-1:0]   r_rem;
    logic [DATA_W-1:0]   r_quo;
    logic [DATA_W-1:0]   r_dvs;
    logic                r_qneg;
    logic                r_rneg;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;

    logic                w_neg1;
    logic                w_neg2;
    logic [DATA_W-1:0]   w_abs1;
    logic [DATA_W-1:0]   w_abs2;
    logic [2*DATA_W-1:0] w_ea;
    logic [2*DATA_W-1:0] w_eb;
    logic [2*DATA_W-1:0] w_prod;
    logic [DATA_W-1:0]   w_rem_nxt;
    logic [DATA_W-1:0]   w_quo_nxt;

    assign w_neg1 = ~bus.op[0] & bus.src1[DATA_W-1];
    assign w_neg2 = ~bus.op[0] & bus.src2[DATA_W-1];
    assign w_abs1 = w_neg1 ? -bus.src1 : bus.src1;
    assign w_abs2 = w_neg2 ? -bus.src2 : bus.src2;

    // Sign-extend to full width so one unsigned multiply serves both ops.
    assign w_ea   = {{DATA_W{r_signed & r_a[DATA_W-1]}}, r_a};
    assign w_eb   = {{DATA_W{r_signed & r_b[DATA_W-1]}}, r_b};
    assign w_prod = w_ea * w_eb;

    div_core #(.DATA_W(DATA_W)) u_div_core (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_dvs (r_dvs),
        .o_rem (w_rem_nxt),
        .o_quo (w_quo_nxt)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_early  <= 1'b0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvs    <= '0;
            r_qneg   <= 1'b0;
            r_rneg   <= 1'b0;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else if (bus.flush) begin
            r_state <= S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.op_valid) begin
                        r_a      <= bus.src1;
                        r_b      <= bus.src2;
                        r_signed <= ~bus.op[0];
                        r_early  <= 1'b0;
                        if (!bus.op[1]) begin
                            r_state <= S_MUL;
                        end else if (bus.src2 == '0) begin
                            r_state <= S_DIV_ZERO;
`ifdef MULDIV_DIV_EARLY_EXIT_EN
                        end else if (w_abs1 < w_abs2) begin
                            r_state <= S_DIV_ZERO;
                            r_early <= 1'b1;
`endif
                        end else begin
                            r_state <= S_DIV_ON;
                            r_rem   <= '0;
                            r_quo   <= w_abs1;
                            r_dvs   <= w_abs2;
                            r_qneg  <= w_neg1 ^ w_neg2;
                            r_rneg  <= w_neg1;
                            r_cnt   <= '0;
                        end
                    end
                end
                S_MUL: begin
                    if (!bus.op_valid) begin
                        r_state <= S_IDLE;
                    end else begin
                        {r_hi, r_lo} <= w_prod;
                        r_state      <= S_DONE;
                    end
                end
                // Shared by divide-by-zero and the early-exit shortcut.
                S_DIV_ZERO: begin
                    if (!bus.op_valid) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_hi    <= r_a;
                        r_lo    <= r_early ? '0 : '1;
                        r_state <= S_DONE;
                    end
                end
                S_DIV_ON: begin
                    if (!bus.op_valid) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_rem <= w_rem_nxt;
                        r_quo <= w_quo_nxt;
                        if (r_cnt == LAST) begin
                            r_hi    <= r_rneg ? -w_rem_nxt : w_rem_nxt;
                            r_lo    <= r_qneg ? -w_quo_nxt : w_quo_nxt;
                            r_state <= S_DONE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (bus.accept) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.stallreq     = resetn & bus.op_valid & ~bus.flush
                              & (r_state != S_DONE);
    assign bus.result_valid = (r_state == S_DONE);
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.hi           = r_hi;
    assign bus.lo           = r_lo;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: expected {hi,lo} queued at issue,
// popped and compared when result_valid rises.
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    logic clk;
    logic resetn;
    int   n_chk;
    int   n_bad;
    logic [63:0] sb[$];

    muldiv_ctrl_if #(.DATA_W(32)) bus ();

    muldiv_ctrl #(.DATA_W(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa;
        longint sb_;
        longint q;
        longint r;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        if (op == MULDIV_MULT) return sa * sb_;
        if (op == MULDIV_MULTU) return {32'h0, a} * {32'h0, b};
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (op == MULDIV_DIV) begin
            q = sa / sb_;
            r = sa % sb_;
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    function automatic int exp_lat(input logic [1:0] op,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        logic [31:0] ma;
        logic [31:0] mb;
        if (!op[1]) return 2;
        if (b == 32'h0) return 2;
        ma = (op == MULDIV_DIV && a[31]) ? -a : a;
        mb = (op == MULDIV_DIV && b[31]) ? -b : b;
`ifdef MULDIV_DIV_EARLY_EXIT_EN
        if (ma < mb) return 2;
`else
        if (ma < mb) return 33;
`endif
        return 33;
    endfunction

    task automatic do_op(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int hold);
        logic [63:0] e;
        int lat;
        int n;
        int st;
        sb.push_back(model(op, a, b));
        lat = exp_lat(op, a, b);
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op       = op;
        bus.src1     = a;
        bus.src2     = b;
        #1;
        n  = 0;
        st = 0;
        while (!bus.result_valid && n < 100) begin
            if (bus.stallreq) st++;
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", 64'(n), 64'(lat));
        chk("stall_cycles", 64'(st), 64'(lat));
        chk("stall_done", 64'(bus.stallreq), 64'd0);
        e = sb.pop_front();
        for (int i = 0; i <= hold; i++) begin
            chk("hi", 64'(bus.hi), 64'(e[63:32]));
            chk("lo", 64'(bus.lo), 64'(e[31:0]));
            chk("rv_hold", 64'(bus.result_valid), 64'd1);
            if (i < hold) begin
                @(posedge clk);
                #1;
            end
        end
        bus.accept = 1'b1;
        @(posedge clk);
        #1;
        bus.accept   = 1'b0;
        bus.op_valid = 1'b0;
        chk("busy_after_acc", 64'(bus.busy), 64'd0);
        chk("rv_after_acc", 64'(bus.result_valid), 64'd0);
    endtask

    initial begin
        int seen;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [1:0]  rop;
        n_chk = 0;
        n_bad = 0;
        resetn       = 1'b0;
        bus.flush    = 1'b0;
        bus.op_valid = 1'b0;
        bus.op       = 2'b00;
        bus.src1     = '0;
        bus.src2     = '0;
        bus.accept   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_rv", 64'(bus.result_valid), 64'd0);
        chk("rst_hi", 64'(bus.hi), 64'd0);
        chk("rst_lo", 64'(bus.lo), 64'd0);
        bus.op_valid = 1'b1;
        #1;
        chk("rst_stall", 64'(bus.stallreq), 64'd0);
        bus.op_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;

        do_op(MULDIV_DIVU, 32'd100, 32'd7, 0);
        do_op(MULDIV_DIV, 32'hFFFF_FFF9, 32'd2, 0);
        do_op(MULDIV_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op(MULDIV_MULT, 32'hFFFF_FFFF, 32'd2, 0);
        do_op(MULDIV_MULTU, 32'hFFFF_FFFF, 32'd2, 0);
        do_op(MULDIV_DIVU, 32'h1234, 32'd0, 0);
        do_op(MULDIV_DIVU, 32'd3, 32'd7, 0);
        do_op(MULDIV_DIV, 32'hFFFF_FFFD, 32'd7, 0);
        do_op(MULDIV_DIV, 32'hFFFF_FF00, 32'hFFFF_FFF0, 0);

        // flush at divide iteration 10
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op       = MULDIV_DIVU;
        bus.src1     = 32'd1000;
        bus.src2     = 32'd3;
        repeat (11) @(posedge clk);
        @(negedge clk);
        chk("busy_pre_flush", 64'(bus.busy), 64'd1);
        bus.flush = 1'b1;
        #1;
        chk("flush_stall", 64'(bus.stallreq), 64'd0);
        @(posedge clk);
        #1;
        chk("flush_busy", 64'(bus.busy), 64'd0);
        chk("flush_rv", 64'(bus.result_valid), 64'd0);
        bus.flush    = 1'b0;
        bus.op_valid = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.result_valid) seen = 1;
        end
        chk("flush_no_result", 64'(seen), 64'd0);
        do_op(MULDIV_DIVU, 32'd9, 32'd3, 0);

        // flush and op_valid together: nothing starts
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op       = MULDIV_MULT;
        bus.flush    = 1'b1;
        #1;
        chk("flush_op_stall", 64'(bus.stallreq), 64'd0);
        @(posedge clk);
        #1;
        chk("flush_op_busy", 64'(bus.busy), 64'd0);
        bus.flush    = 1'b0;
        bus.op_valid = 1'b0;

        // asynchronous reset mid-divide
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op       = MULDIV_DIV;
        bus.src1     = 32'd500;
        bus.src2     = 32'hFFFF_FFFD;
        repeat (15) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_busy", 64'(bus.busy), 64'd0);
        chk("arst_hi", 64'(bus.hi), 64'd0);
        chk("arst_lo", 64'(bus.lo), 64'd0);
        chk("arst_rv", 64'(bus.result_valid), 64'd0);
        chk("arst_stall", 64'(bus.stallreq), 64'd0);
        bus.op_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;

        do_op(MULDIV_DIVU, 32'd50, 32'd5, 5);

        // op_valid drops while in MUL: abort, no result
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op       = MULDIV_MULT;
        bus.src1     = 32'd6;
        bus.src2     = 32'd7;
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
        seen = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (bus.result_valid) seen = 1;
        end
        chk("abort_no_result", 64'(seen), 64'd0);
        chk("abort_busy", 64'(bus.busy), 64'd0);

        // accept while idle is ignored
        bus.accept = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_acc_busy", 64'(bus.busy), 64'd0);
        chk("idle_acc_rv", 64'(bus.result_valid), 64'd0);
        bus.accept = 1'b0;

        for (int i = 0; i < 6; i++) begin
            ra  = $urandom;
            rb  = $urandom_range(0, 3) == 0 ? 32'($urandom_range(1, 40)) : $urandom;
            rop = 2'($urandom_range(0, 3));
            do_op(rop, ra, rb, 0);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Multi-cycle MULT/MULTU/DIV/DIVU sequencer for the EX stage. It owns the HI/LO-producing arithmetic resource and raises a stall request while an operation runs. It presents the 64-bit {hi,lo} result once, holds it until the pipeline accepts it, and aborts cleanly on flush. It sits beside the ALU in EX. Its result feeds the HI/LO fields of the EX-to-MEM bus.

Parameters:
DATA_W, 32, operand width; hi/lo are DATA_W each; the iteration counter is clog2(DATA_W)+1 bits wide.

Ports:
clk  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
flush  in  1  pipeline flush; kills any in-flight operation
op_valid  in  1  EX holds a mul/div instruction this cycle
op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
src1  in  DATA_W  rs operand (dividend / multiplicand)
src2  in  DATA_W  rt operand (divisor / multiplier)
accept  in  1  EX advances this cycle (stall[2] released)
stallreq  out  1  combinational stall request to the stall controller
result_valid  out  1  hi/lo valid
hi  out  DATA_W  MULT: product[63:32]; DIV: remainder
lo  out  DATA_W  MULT: product[31:0]; DIV: quotient
busy  out  1  state != IDLE

Behaviour:
- resetn low, asynchronous: state=IDLE; hi, lo, counter and internal regs = 0; result_valid=0; busy=0. stallreq follows its equation, forced 0 during reset.
- States: IDLE, MUL, DIV_ZERO, DIV_ON, DONE.
- IDLE:
  - op_valid & ~flush & op[1]=0 -> MUL.
  - op[1]=1 & src2==0 -> DIV_ZERO.
  - op[1]=1 & src2!=0 -> DIV_ON. Latch |src1| and |src2| (signed ops only), quotient sign = src1[31]^src2[31], remainder sign = src1[31], counter=0.
- MUL: 1 cycle. Register the 64-bit product from the operands latched at IDLE (signed for MULT, unsigned for MULTU). -> DONE.
- DIV_ZERO: hi=src1, lo=all ones. -> DONE.
- DIV_ON: one restoring shift-subtract step per cycle. Stay for DATA_W cycles (counter 0..DATA_W-1), then apply the sign fix-up and -> DONE.
- DONE: result_valid=1; hold hi/lo stable. accept -> IDLE (result_valid=0 next cycle). A new op is not sampled in the DONE cycle.
- stallreq = op_valid & ~flush & (state != DONE).
- Latency, op_valid sampled at edge 0:
  - MUL: result_valid visible after edge 2.
  - DIV: result_valid visible after edge DATA_W+1 (33).
  - Divide by zero: after edge 2.
- flush in any state: -> IDLE next edge; result_valid=0; stallreq=0 that cycle. Flush and op_valid in the same cycle: flush wins, nothing starts.
- op_valid drops in MUL/DIV_ON/DIV_ZERO without flush: abort to IDLE, no result.
- accept held high in IDLE has no effect.
- Signed overflow 0x80000000 / -1: lo=0x80000000, hi=0, no trap.
- Reset mid-operation: immediate return to the reset values; no partial result visible.

Optional Feature:
MULDIV_DIV_EARLY_EXIT_EN
- Defined: in IDLE, if a divide has |src1| < |src2|, go straight to DONE next edge with lo=0, hi=src1 (sign preserved). Latency 2 edges.
- Undefined: all nonzero-divisor divides take the full DATA_W iterations. Latency is fixed at DATA_W+1 edges.

Decomposition:
- Constants in lib/defines.vh: op encodings (MULDIV_MULT/MULTU/DIV/DIVU), state encodings, HILO_BUS width.
- One natural sub-module, div_core: a single restoring iteration step, with inputs partial remainder, quotient and divisor, and outputs the next remainder and quotient. muldiv_ctrl owns the counter, FSM, sign handling and multiplier.

Test Plan:
- DIVU src1=100 src2=7 -> stallreq high 33 cycles; then result_valid=1, lo=14, hi=2, stallreq=0; accept -> IDLE.
- DIV src1=0xFFFFFFF9 (-7) src2=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- MULT 0xFFFFFFFF x 2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE after 2 edges. MULTU same operands -> hi=1, lo=0xFFFFFFFE.
- DIVU src2=0, src1=0x1234 -> after 2 edges hi=0x1234, lo=0xFFFFFFFF.
- Flush at DIV_ON iteration 10 -> IDLE next edge, result_valid never asserts. A following DIVU 9/3 runs the full 33 edges: lo=3, hi=0.
- resetn low mid-DIV_ON -> asynchronous return to IDLE, hi=lo=0, busy=0. DONE held with accept=0 for 5 cycles -> hi/lo stable, stallreq=0. With MULDIV_DIV_EARLY_EXIT_EN defined, DIVU 3/7 -> lo=0, hi=3 after 2 edges.
